// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous RAM.
// Grants are combinational; responses return one cycle later via an in-flight tag.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter bit RR         = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic        d_misalign,
    output logic [31:0] d_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]  starve_q, starve_d;
    logic        rr_fetch_q, rr_fetch_d;
    logic        tag_vld_q, tag_vld_d;
    logic        tag_dat_q, tag_dat_d;
    logic        tag_we_q, tag_we_d;
    logic        tag_mis_q, tag_mis_d;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        conflict, fetch_win;

    always_comb begin
        conflict  = i_req & d_req;
        fetch_win = RR ? rr_fetch_q : (starve_q == SMAX);
        i_gnt     = i_req & (~d_req | fetch_win);
        d_gnt     = d_req & ~i_gnt;
        ram_en    = i_req | d_req;
        ram_we    = d_gnt & d_we;
        ram_addr  = d_gnt ? d_addr : i_addr;
        ram_di    = d_gnt ? d_wdata : '0;

        // Fetch's starvation count only matters under fixed data priority.
        starve_d = starve_q;
        if (RR || i_gnt)
            starve_d = '0;
        else if (conflict && starve_q != SMAX)
            starve_d = starve_q + 4'd1;

        rr_fetch_d = rr_fetch_q;
        if (RR && conflict)
            rr_fetch_d = ~rr_fetch_q;

        tag_vld_d = ram_en;
        tag_dat_d = d_gnt;
        tag_we_d  = d_gnt & d_we;
        tag_mis_d = d_gnt & (d_addr[1:0] != 2'b00);
    end

    always_comb begin
        i_valid    = tag_vld_q & ~tag_dat_q;
        d_valid    = tag_vld_q & tag_dat_q;
        d_misalign = d_valid & tag_mis_q;
        // Fresh RAM data is forwarded on the pulse, then held in the capture register.
        i_rdata    = i_valid ? ram_dout : i_rdata_q;
        d_rdata    = (d_valid & ~tag_we_q) ? ram_dout : d_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            rr_fetch_q <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_dat_q  <= 1'b0;
            tag_we_q   <= 1'b0;
            tag_mis_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            rr_fetch_q <= rr_fetch_d;
            tag_vld_q  <= tag_vld_d;
            tag_dat_q  <= tag_dat_d;
            tag_we_q   <= tag_we_d;
            tag_mis_q  <= tag_mis_d;
            i_rdata_q  <= i_rdata;
            d_rdata_q  <= d_rdata;
        end
    end
endmodule
